// File: rtl/sum_parallel_lanes.sv
// Frame summer: spreads N_SAMPLES valid-qualified samples across LANES interleaved
// lane accumulators, then reduces the lanes into one registered frame sum.
module sum_parallel_lanes #(
  parameter int DATA_W    = 8,
  parameter int N_SAMPLES = 128,
  parameter int LANES     = 4,
  parameter int SIGNED    = 0,
  localparam int SUM_W    = DATA_W + $clog2(N_SAMPLES)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              data_start,
  output logic              busy,
  output logic [SUM_W-1:0]  sum,
  output logic              sum_valid,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(N_SAMPLES);
  localparam int ACC_W = DATA_W + $clog2(N_SAMPLES / LANES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_REDUCE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               sum_valid_q, sum_valid_d;
  logic               frame_err_q, frame_err_d;

  logic               start_req;
  logic               accept;
  logic               restart;
  logic [CNT_W-1:0]   slot;
  logic [SUM_W-1:0]   acc_ext [LANES];
  logic [SUM_W-1:0]   lane_total;

  assign start_req = data_valid && data_start;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    restart     = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_req) begin
          accept  = 1'b1;
          restart = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (start_req) begin
          // Abort: the new start becomes sample 0 of a fresh frame.
          accept      = 1'b1;
          restart     = 1'b1;
          frame_err_d = 1'b1;
          cnt_d       = CNT_W'(1);
        end else if (data_valid) begin
          accept = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N_SAMPLES - 1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        frame_err_d = start_req;
        state_d     = S_REDUCE;
      end
      S_REDUCE: begin
        frame_err_d = start_req;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign slot = restart ? '0 : cnt_q;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_W-1:0] reg_q;
      logic              pend_q;
      logic [ACC_W-1:0]  acc_q, acc_d;
      logic [ACC_W-1:0]  reg_ext;
      logic              hit;
      logic              sign_bit;

      assign hit      = accept && ((slot & CNT_W'(LANES - 1)) == CNT_W'(gi));
      assign sign_bit = (SIGNED != 0) && reg_q[DATA_W-1];
      assign reg_ext  = {{(ACC_W - DATA_W){sign_bit}}, reg_q};
      // A restart discards any add still pending from the aborted frame.
      assign acc_d    = restart ? '0 : (pend_q ? acc_q + reg_ext : acc_q);

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          reg_q  <= '0;
          pend_q <= 1'b0;
          acc_q  <= '0;
        end else begin
          if (hit) begin
            reg_q <= data_in;
          end
          pend_q <= hit;
          acc_q  <= acc_d;
        end
      end

      if (SUM_W > ACC_W) begin : g_widen
        assign acc_ext[gi] = {{(SUM_W - ACC_W){(SIGNED != 0) && acc_q[ACC_W-1]}}, acc_q};
      end else begin : g_same
        assign acc_ext[gi] = acc_q;
      end
    end
  endgenerate

  always_comb begin
    lane_total = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_total = lane_total + acc_ext[l];
    end
  end

  always_comb begin
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    if (state_q == S_REDUCE) begin
      sum_d       = lane_total;
      sum_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sum_parallel_lanes.sv
// Scoreboard bench: four summer variants (default, signed, 1 lane, 8 lanes) share one
// stimulus stream; a negedge monitor checks each result against queued expectations.
module tb_sum_parallel_lanes;

  localparam int ND = 4;
  localparam int SW = 15;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [7:0]    data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_start = 1'b0;

  logic [SW-1:0] sum_w   [ND];
  logic          sv_w    [ND];
  logic          busy_w  [ND];
  logic          ferr_w  [ND];

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  sum_parallel_lanes #(.DATA_W(8), .N_SAMPLES(128), .LANES(4), .SIGNED(0)) dut_u (
    .CLK(CLK), .RST(RST), .data_in(data_in), .data_valid(data_valid), .data_start(data_start),
    .busy(busy_w[0]), .sum(sum_w[0]), .sum_valid(sv_w[0]), .frame_err(ferr_w[0]));
  sum_parallel_lanes #(.DATA_W(8), .N_SAMPLES(128), .LANES(4), .SIGNED(1)) dut_s (
    .CLK(CLK), .RST(RST), .data_in(data_in), .data_valid(data_valid), .data_start(data_start),
    .busy(busy_w[1]), .sum(sum_w[1]), .sum_valid(sv_w[1]), .frame_err(ferr_w[1]));
  sum_parallel_lanes #(.DATA_W(8), .N_SAMPLES(128), .LANES(1), .SIGNED(0)) dut_l1 (
    .CLK(CLK), .RST(RST), .data_in(data_in), .data_valid(data_valid), .data_start(data_start),
    .busy(busy_w[2]), .sum(sum_w[2]), .sum_valid(sv_w[2]), .frame_err(ferr_w[2]));
  sum_parallel_lanes #(.DATA_W(8), .N_SAMPLES(128), .LANES(8), .SIGNED(0)) dut_l8 (
    .CLK(CLK), .RST(RST), .data_in(data_in), .data_valid(data_valid), .data_start(data_start),
    .busy(busy_w[3]), .sum(sum_w[3]), .sum_valid(sv_w[3]), .frame_err(ferr_w[3]));

  typedef struct {
    logic [SW-1:0] sum_u;
    logic [SW-1:0] sum_s;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   ferr_cnt [ND];
  int   ferr_last [ND];
  int   last_cyc = 0;

  task automatic check(input string name, input int d, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, d, cyc, act, exp);
    end
  endtask

  // Monitor: pops one expectation per result pulse and tallies frame_err pulses.
  initial begin
    for (int d = 0; d < ND; d++) begin
      ferr_cnt[d]  = 0;
      ferr_last[d] = -1;
    end
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (sv_w[0] || sv_w[1] || sv_w[2] || sv_w[3]) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_sum_valid cycle %0d: got sum_valid=1, expected 0", cyc);
          end else begin
            mon_e = exp_q.pop_front();
            check("latency", 0, cyc, mon_e.cyc);
            for (int d = 0; d < ND; d++) begin
              check("sum_valid", d, sv_w[d], 1);
              check("sum", d, sum_w[d], (d == 1) ? mon_e.sum_s : mon_e.sum_u);
              check("busy_at_result", d, busy_w[d], 0);
            end
            $display("result cycle %0d: sum dut0=%0h dut1=%0h dut2=%0h dut3=%0h",
                     cyc, sum_w[0], sum_w[1], sum_w[2], sum_w[3]);
          end
        end
        for (int d = 0; d < ND; d++) begin
          if (ferr_w[d]) begin
            ferr_cnt[d]++;
            ferr_last[d] = cyc;
          end
        end
      end
    end
  end

  task automatic drive(input logic [7:0] v, input logic st);
    @(negedge CLK);
    data_in    = v;
    data_valid = 1'b1;
    data_start = st;
    last_cyc   = cyc;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge CLK);
      data_valid = 1'b0;
      data_start = 1'b0;
    end
  endtask

  task automatic push(input logic [SW-1:0] u, input logic [SW-1:0] s);
    exp_t e;
    e.sum_u = u;
    e.sum_s = s;
    e.cyc   = last_cyc + 3;
    exp_q.push_back(e);
  endtask

  task automatic const_frame(input logic [7:0] v);
    for (int k = 0; k < 128; k++) drive(v, k == 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int restart_cyc;
    int base_err;

    #3;
    for (int d = 0; d < ND; d++) begin
      check("reset_busy", d, busy_w[d], 0);
      check("reset_sum", d, sum_w[d], 0);
      check("reset_sum_valid", d, sv_w[d], 0);
      check("reset_frame_err", d, ferr_w[d], 0);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    gap(2);

    // 128 x 0xFF: 32640 unsigned; -128 signed also encodes as 15'h7F80.
    const_frame(8'hFF);
    push(15'h7F80, 15'h7F80);
    gap(4);

    // Ramp 0..127 with a bubble after every sample.
    for (int k = 0; k < 128; k++) begin
      drive(8'(k), k == 0);
      if (k == 127) push(15'd8128, 15'd8128);
      gap(1);
    end
    gap(4);

    const_frame(8'h80);
    push(15'h4000, 15'h4000);
    gap(4);

    for (int k = 0; k < 128; k++) drive((k % 2 == 0) ? 8'h7F : 8'h81, k == 0);
    push(15'h4000, 15'h0000);
    gap(4);

    // Abort after 50 samples of 1; restart with 128 samples of 2.
    base_err = ferr_cnt[0];
    for (int k = 0; k < 50; k++) drive(8'd1, k == 0);
    drive(8'd2, 1'b1);
    restart_cyc = last_cyc;
    for (int k = 1; k < 128; k++) drive(8'd2, 1'b0);
    push(15'd256, 15'd256);
    gap(4);
    for (int d = 0; d < ND; d++) begin
      check("restart_err_count", d, ferr_cnt[d], base_err + 1);
      check("restart_err_cycle", d, ferr_last[d], restart_cyc + 1);
    end

    // Starts offered during DRAIN and REDUCE are rejected with frame_err.
    const_frame(8'd1);
    push(15'd128, 15'd128);
    drive(8'h55, 1'b1);
    drive(8'h55, 1'b1);
    gap(3);
    for (int d = 0; d < ND; d++) begin
      check("late_start_err_count", d, ferr_cnt[d], base_err + 3);
      check("idle_after_late_start", d, busy_w[d], 0);
    end

    // Asynchronous reset mid-frame.
    for (int k = 0; k < 60; k++) drive(8'd1, k == 0);
    @(posedge CLK);
    #1;
    data_valid = 1'b0;
    data_start = 1'b0;
    #1;
    RST = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      check("async_rst_busy", d, busy_w[d], 0);
      check("async_rst_sum", d, sum_w[d], 0);
      check("async_rst_sum_valid", d, sv_w[d], 0);
      check("async_rst_frame_err", d, ferr_w[d], 0);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    gap(2);

    const_frame(8'd1);
    push(15'd128, 15'd128);
    gap(4);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge CLK);
    check("queue_drained", 0, exp_q.size(), 0);
    for (int d = 0; d < ND; d++) check("total_frame_err", d, ferr_cnt[d], 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
